// File: rtl/regfile_write_port_arbiter.sv
// rtl/regfile_write_port_arbiter.sv - round-robin arbiter sharing the register-file write port
// Optional build macro ZERO_REG_DISCARD_EN: writes to the top register are accepted but not strobed.
module regfile_write_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       HOLD,
  input  logic [N_REQ-1:0]           REQ_VALID,
  input  logic [N_REQ*ADDR_W-1:0]    REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]    REQ_DATA,
  output logic [N_REQ-1:0]           REQ_READY,
  output logic                       WR_EN,
  output logic [ADDR_W-1:0]          WR_SEL,
  output logic [DATA_W-1:0]          WR_DATA,
  output logic [2:0]                 GRANT_ID
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              wr_fire;
  logic [N_REQ-1:0]  ready_c;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = REQ_ADDR[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = REQ_DATA[i*DATA_W +: DATA_W];
  end

  // Search starts just after the last granted source so it has lowest priority.
  always_comb begin
    ready_c  = '0;
    idx      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    gnt_addr = '0;
    gnt_data = '0;
    if (RESET_N && !HOLD) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = IDX_W'((int'(ptr) + k) % N_REQ);
        if (!gnt_any && REQ_VALID[idx]) begin
          gnt_any      = 1'b1;
          gnt_idx      = idx;
          gnt_addr     = addr_arr[idx];
          gnt_data     = data_arr[idx];
          ready_c[idx] = 1'b1;
        end
      end
    end
  end

  assign REQ_READY = ready_c;

`ifdef ZERO_REG_DISCARD_EN
  assign wr_fire = gnt_any && (gnt_addr != {ADDR_W{1'b1}});
`else
  assign wr_fire = gnt_any;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WR_EN    <= 1'b0;
      WR_SEL   <= '0;
      WR_DATA  <= '0;
      GRANT_ID <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
    end else begin
      WR_EN <= wr_fire;
      if (gnt_any) begin
        WR_SEL   <= gnt_addr;
        WR_DATA  <= gnt_data;
        GRANT_ID <= 3'(gnt_idx);
        ptr      <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_port_arbiter.sv
// tb/tb_regfile_write_port_arbiter.sv - directed scoreboard bench for regfile_write_port_arbiter
module tb_regfile_write_port_arbiter;

  logic         clk;
  logic         rst_n;
  logic         hold;
  logic [3:0]   req_valid;
  logic [23:0]  req_addr;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         wr_en;
  logic [5:0]   wr_sel;
  logic [63:0]  wr_data;
  logic [2:0]   grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [5:0]  sel;
    logic [63:0] data;
    logic [2:0]  id;
  } exp_t;

  exp_t sbq[$];

  int          m_ptr;
  logic        m_en;
  logic [5:0]  m_sel;
  logic [63:0] m_data;
  logic [2:0]  m_id;

  regfile_write_port_arbiter #(.N_REQ(4), .ADDR_W(6), .DATA_W(64)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .HOLD      (hold),
    .REQ_VALID (req_valid),
    .REQ_ADDR  (req_addr),
    .REQ_DATA  (req_data),
    .REQ_READY (req_ready),
    .WR_EN     (wr_en),
    .WR_SEL    (wr_sel),
    .WR_DATA   (wr_data),
    .GRANT_ID  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [5:0] a, input logic [63:0] d);
    req_addr[i*6 +: 6]   = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic model_reset();
    m_ptr  = 3;
    m_en   = 1'b0;
    m_sel  = '0;
    m_data = '0;
    m_id   = '0;
    sbq.delete();
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic [3:0] er;
    int         g;
    exp_t       e;
    #1;
    er = 4'b0000;
    g  = -1;
    if (!hold) begin
      for (int k = 1; k <= 4; k++) begin
        int n;
        n = (m_ptr + k) % 4;
        if (g < 0 && req_valid[n]) g = n;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk($sformatf("%s ready", tag), 64'(req_ready), 64'(er));
    if (g >= 0) begin
      m_sel  = req_addr[g*6 +: 6];
      m_data = req_data[g*64 +: 64];
      m_id   = 3'(g);
      m_ptr  = g;
      m_en   = 1'b1;
`ifdef ZERO_REG_DISCARD_EN
      if (m_sel == 6'd63) m_en = 1'b0;
`endif
    end else begin
      m_en = 1'b0;
    end
    e.en = m_en; e.sel = m_sel; e.data = m_data; e.id = m_id;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s wr_en", tag),    64'(wr_en),    64'(e.en));
      chk($sformatf("%s wr_sel", tag),   64'(wr_sel),   64'(e.sel));
      chk($sformatf("%s wr_data", tag),  wr_data,       e.data);
      chk($sformatf("%s grant_id", tag), 64'(grant_id), 64'(e.id));
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_data  = '0;
    model_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(i + 1), 64'h1000 + 64'(i));
    #3;
    chk("reset ready",    64'(req_ready), 64'h0);
    chk("reset wr_en",    64'(wr_en),     64'h0);
    chk("reset wr_sel",   64'(wr_sel),    64'h0);
    chk("reset wr_data",  wr_data,        64'h0);
    chk("reset grant_id", 64'(grant_id),  64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first ready after reset", 64'(req_ready), 64'h1);
    for (int c = 0; c < 8; c++) cycle($sformatf("rr%0d", c));

    req_valid = 4'b0100;
    set_src(2, 6'd17, 64'hDEAD_BEEF);
    cycle("single");
    req_valid = 4'b0000;
    cycle("single idle");

    req_valid = 4'b0010;
    set_src(1, 6'd9, 64'h99);
    cycle("grant1");
    req_valid = 4'b1111;
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) cycle($sformatf("hold%0d", c));
    hold = 1'b0;
    #1;
    chk("hold release ready", 64'(req_ready), 64'h4);
    cycle("hold release");
    req_valid = 4'b0000;
    cycle("post hold idle");

    req_valid = 4'b1000;
    set_src(3, 6'd10, 64'hA);
    cycle("ptr to 3");
    set_src(0, 6'd5, 64'd1);
    set_src(3, 6'd5, 64'd2);
    req_valid = 4'b1001;
    cycle("same addr first");
    chk("same addr first data", wr_data, 64'd1);
    req_valid = 4'b1000;
    cycle("same addr second");
    chk("same addr second data", wr_data, 64'd2);
    req_valid = 4'b0000;
    cycle("same addr idle");

    req_valid = 4'b0010;
    set_src(1, 6'd63, 64'h6363);
    cycle("zero reg");
`ifdef ZERO_REG_DISCARD_EN
    chk("zero reg wr_en", 64'(wr_en), 64'h0);
`else
    chk("zero reg wr_en", 64'(wr_en), 64'h1);
`endif
    chk("zero reg grant_id", 64'(grant_id), 64'h1);
    req_valid = 4'b0000;
    cycle("zero reg idle");

    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      set_src(2, 6'(20 + c), 64'hB000 + 64'(c));
      cycle($sformatf("lone%0d", c));
    end
    req_valid = 4'b0000;
    cycle("lone idle");

    for (int c = 0; c < 40; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      hold      = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) set_src(i, 6'($urandom), {$urandom, $urandom});
      cycle($sformatf("rand%0d", c));
    end
    hold = 1'b0;

    req_valid = 4'b1111;
    cycle("pre reset write");
    rst_n = 1'b0;
    #1;
    chk("mid reset wr_en",    64'(wr_en),     64'h0);
    chk("mid reset ready",    64'(req_ready), 64'h0);
    chk("mid reset wr_sel",   64'(wr_sel),    64'h0);
    chk("mid reset grant_id", 64'(grant_id),  64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("after mid reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_port_arbiter.md
Name: regfile_write_port_arbiter

Overview:
- Shares the single register-file write port among N_REQ writeback sources, e.g. ALU, load unit, multiplier and branch-link.
- Drives the 6-bit-select 1-to-64 write-enable demux:
  - WR_EN feeds the demux data input.
  - WR_SEL feeds the demux select.
  - WR_DATA goes to all 64 registers.
- Round-robin arbitration with a valid/ready handshake per source; one registered write per cycle.

Parameters:
- N_REQ, 4, number of writeback requesters (2..8).
- ADDR_W, 6, register address width; equals the demux select width.
- DATA_W, 64, write data width.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- HOLD  input  1  pipeline freeze; no grant while high.
- REQ_VALID  input  N_REQ  per-source write request.
- REQ_ADDR  input  N_REQ*ADDR_W  packed destination addresses; source i in [i*ADDR_W +: ADDR_W].
- REQ_DATA  input  N_REQ*DATA_W  packed write data; source i in [i*DATA_W +: DATA_W].
- REQ_READY  output  N_REQ  one-hot or zero; source i is accepted this cycle.
- WR_EN  output  1  registered write strobe to the demux input.
- WR_SEL  output  ADDR_W  registered register address to the demux select.
- WR_DATA  output  DATA_W  registered write data.
- GRANT_ID  output  3  registered index of the source that produced the current write.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset RESET_N is asynchronous, active-low.
  - While RESET_N=0: WR_EN=0, WR_SEL=0, WR_DATA=0, GRANT_ID=0, round-robin pointer PTR=N_REQ-1.
  - REQ_READY is combinational; it is 0 during reset.
- Arbitration (combinational):
  - If HOLD=0, search sources starting at PTR+1 modulo N_REQ, wrapping.
  - The first i with REQ_VALID[i]=1 gets REQ_READY[i]=1; all other READY bits are 0.
  - If HOLD=1 or no VALID bit is set, REQ_READY=0.
- Handshake:
  - A transfer occurs when REQ_VALID[i] & REQ_READY[i] at a rising edge.
  - A source holds VALID, ADDR and DATA stable until its transfer.
  - VALID may drop only after the transfer. Dropping it earlier is a protocol violation and the write is simply not performed.
- Latency: exactly 1 cycle. The edge that completes a transfer loads WR_EN=1, WR_SEL=addr, WR_DATA=data, GRANT_ID=i, PTR=i.
- Idle cycle:
  - The cycle after an edge with no transfer has WR_EN=0.
  - WR_SEL, WR_DATA and GRANT_ID keep their last values.
  - PTR is unchanged.
- HOLD:
  - Blocks new grants in the same cycle.
  - WR_EN drops on the following edge.
  - PTR is frozen.
  - A write already presented (WR_EN=1) is not cancelled.
- Fairness:
  - After a grant to i, source i has lowest priority next cycle.
  - With all sources continuously valid, grants rotate 0,1,..,N_REQ-1,0,...
  - Worst-case wait is N_REQ-1 cycles when HOLD=0.
- Single requester: a continuously valid lone source is granted every cycle (back-to-back WR_EN=1).
- Same address from two sources: both are written in arbitration order, each in its own cycle. Later write wins; no merging.
- Reset mid-operation: pending requests are not remembered; sources re-present. An output write in flight is cleared (WR_EN=0).
- Address range: any value 0..2^ADDR_W-1 is legal; no range check.

Optional Feature:
- Macro: ZERO_REG_DISCARD_EN.
- Defined:
  - A transfer with address 2^ADDR_W-1 (register 63, the zero register) is accepted normally: READY asserted, PTR updated.
  - WR_EN stays 0 for that cycle, so no demux output fires.
  - WR_SEL, WR_DATA and GRANT_ID still update.
- Undefined: address 63 is written like any other register.

Test Plan:
- Reset: hold RESET_N=0 with REQ_VALID=4'b1111 -> REQ_READY=0, WR_EN=0, WR_SEL=0. Release reset -> first cycle READY=4'b0001.
- Single write: source 2 valid, addr 6'd17, data 64'hDEAD_BEEF, HOLD=0, others idle -> READY=4'b0100 that cycle. Next cycle WR_EN=1, WR_SEL=17, WR_DATA=64'hDEAD_BEEF, GRANT_ID=2. Following cycle WR_EN=0.
- Round-robin: all four valid for 8 cycles, distinct addresses 1..4 -> grant order 0,1,2,3,0,1,2,3; WR_EN=1 every cycle from cycle 2.
- HOLD: all valid, assert HOLD for 3 cycles after grant to source 1 -> READY=0 for 3 cycles, WR_EN=0 from the next edge. On release, the grant goes to source 2.
- Same-address conflict: sources 0 and 3 both target addr 5 with data 1 and 2, PTR=3 -> writes to addr 5 occur on consecutive cycles in order data 1, then data 2.
- Zero register with ZERO_REG_DISCARD_EN defined: source 1 writes addr 63 -> READY=4'b0010 and GRANT_ID=1 next cycle, WR_EN=0. With the macro undefined, WR_EN=1 and WR_SEL=63.
